// File: rtl/dmem_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_bus_pkg - SIZE/funct3 encodings and FSM states for the data-bus ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package dmem_bus_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Access width lives in funct3[1:0]; byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    return ((width == F3_LH[1:0]) && addr_lo[0]) ||
           ((width == F3_LW[1:0]) && (addr_lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bus_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_bus_ctrl_if - core request/response and external bus control signals
// Rev 1.0
// ---------------------------------------------------------------------------
interface dmem_bus_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            flush;
  logic            stall;
  logic            resp_valid;
  logic [XLEN-1:0] load_data;
  logic            bus_err;
  logic            misalign;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] DAD;
  logic            MREQ;
  logic            WRITE;
  logic [1:0]      SIZE;
  logic            ACKD_n;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, flush, ACKD_n,
    input  stall, resp_valid, load_data, bus_err, misalign, exc_tval,
           DAD, MREQ, WRITE, SIZE
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, flush, ACKD_n,
    output stall, resp_valid, load_data, bus_err, misalign, exc_tval,
           DAD, MREQ, WRITE, SIZE
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_lane_fmt - store data right-justification, load extension, SIZE map
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_lane_fmt
  import dmem_bus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      req_width_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic [XLEN-1:0] st_data_o,
  output logic [1:0]      st_size_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [XLEN-1:0] ld_raw_i,
  output logic [XLEN-1:0] ld_data_o
);

  always_comb begin
    st_data_o = req_wdata_i;
    st_size_o = SZ_WORD;
    case (req_width_i)
      F3_SB[1:0]: begin
        st_data_o = {{(XLEN-8){1'b0}}, req_wdata_i[7:0]};
        st_size_o = SZ_BYTE;
      end
      F3_SH[1:0]: begin
        st_data_o = {{(XLEN-16){1'b0}}, req_wdata_i[15:0]};
        st_size_o = SZ_HALF;
      end
      default: begin
        st_data_o = req_wdata_i;
        st_size_o = SZ_WORD;
      end
    endcase
  end

  always_comb begin
    ld_data_o = ld_raw_i;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{(XLEN-8){ld_raw_i[7]}}, ld_raw_i[7:0]};
      F3_LH:   ld_data_o = {{(XLEN-16){ld_raw_i[15]}}, ld_raw_i[15:0]};
      F3_LBU:  ld_data_o = {{(XLEN-8){1'b0}}, ld_raw_i[7:0]};
      F3_LHU:  ld_data_o = {{(XLEN-16){1'b0}}, ld_raw_i[15:0]};
      F3_LW:   ld_data_o = ld_raw_i;
      default: ld_data_o = ld_raw_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_bus_ctrl - MEM-stage load/store controller for the ACKD_n data bus
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  dmem_bus_ctrl_if.slave    bus,
  inout  wire  [XLEN-1:0]   DDT
);

  state_e            state_q;
  logic              mreq_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   dad_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        funct3_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              resp_valid_q;
  logic              bus_err_q;
  logic [XLEN-1:0]   load_data_q;
  logic [XLEN-1:0]   exc_tval_q;

  logic              misalign;
  logic              accept;
  logic [XLEN-1:0]   st_data;
  logic [1:0]        st_size;
  logic [XLEN-1:0]   ld_data;

  dmem_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
    .req_width_i (bus.req_funct3[1:0]),
    .req_wdata_i (bus.req_wdata),
    .st_data_o   (st_data),
    .st_size_o   (st_size),
    .ld_funct3_i (funct3_q),
    .ld_raw_i    (DDT),
    .ld_data_o   (ld_data)
  );

  assign misalign = bus.req_valid && is_misaligned(bus.req_funct3[1:0], bus.req_addr[1:0]);
  assign accept   = (state_q == IDLE) && bus.req_valid && !misalign && !bus.flush;
  assign cnt_d    = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mreq_q       <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= SZ_WORD;
      dad_q        <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      load_data_q  <= '0;
      exc_tval_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= ACCESS;
            mreq_q   <= 1'b1;
            write_q  <= bus.req_write;
            size_q   <= st_size;
            dad_q    <= bus.req_addr;
            wdata_q  <= st_data;
            funct3_q <= bus.req_funct3;
            cnt_q    <= '0;
          end
        end
        ACCESS: begin
          // flush is deliberately not looked at here: a started access always finishes.
          if (!bus.ACKD_n) begin
            state_q      <= IDLE;
            mreq_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            if (!write_q) begin
              load_data_q <= ld_data;
            end
          end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_q      <= IDLE;
            mreq_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            bus_err_q    <= 1'b1;
            exc_tval_q   <= dad_q;
            cnt_q        <= cnt_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DDT = (mreq_q && write_q) ? wdata_q : {XLEN{1'bz}};

  assign bus.stall      = (state_q == ACCESS) || accept;
  assign bus.resp_valid = resp_valid_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.load_data  = load_data_q;
  assign bus.misalign   = misalign;
  assign bus.exc_tval   = misalign ? bus.req_addr : exc_tval_q;
  assign bus.DAD        = dad_q;
  assign bus.MREQ       = mreq_q;
  assign bus.WRITE      = write_q;
  assign bus.SIZE       = size_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_bus_ctrl - directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_bus_ctrl;
  import dmem_bus_pkg::*;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [1:0]  size;
    logic [31:0] exp;   // DDT value for stores, load_data for loads
  } vec_t;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [31:0] mem_drv;
  wire  [31:0] ddt;
  int          checks;
  int          failures;
  vec_t        vecs[9];

  dmem_bus_ctrl_if #(.XLEN(32)) bus ();

  dmem_bus_ctrl #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .DDT (ddt)
  );

  assign ddt = mem_en ? mem_drv : 32'hzzzz_zzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  // Entered and left just after a rising edge.
  task automatic do_txn(input vec_t v, input string tag);
    int n;
    n = 0;
    drive_req(v.wr, v.f3, v.addr, v.wdata);
    bus.ACKD_n = 1'b1;
    mem_en     = 1'b0;
    @(negedge clk);
    chk({tag, ".stall_accept"}, 32'(bus.stall), 32'd1);
    chk({tag, ".misalign"},     32'(bus.misalign), 32'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= v.lat; k++) begin
      bus.ACKD_n = (k == v.lat) ? 1'b0 : 1'b1;
      mem_en     = !v.wr;
      mem_drv    = v.rdata;
      @(negedge clk);
      if (bus.MREQ) n++;
      if (k == 1) begin
        chk({tag, ".DAD"},   bus.DAD, v.addr);
        chk({tag, ".WRITE"}, 32'(bus.WRITE), 32'(v.wr));
        chk({tag, ".SIZE"},  32'(bus.SIZE), 32'(v.size));
        chk({tag, ".stall_access"}, 32'(bus.stall), 32'd1);
        if (v.wr) chk({tag, ".DDT_store"}, ddt, v.exp);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.ACKD_n    = 1'b1;
    mem_en        = 1'b1;
    mem_drv       = 32'h5A5A_5A5A;
    @(negedge clk);
    chk({tag, ".mreq_cycles"}, 32'(n), 32'(v.lat));
    chk({tag, ".resp_valid"},  32'(bus.resp_valid), 32'd1);
    chk({tag, ".bus_err"},     32'(bus.bus_err), 32'd0);
    chk({tag, ".MREQ_resp"},   32'(bus.MREQ), 32'd0);
    chk({tag, ".stall_resp"},  32'(bus.stall), 32'd0);
    chk({tag, ".DDT_release"}, ddt, 32'h5A5A_5A5A);
    if (!v.wr) chk({tag, ".load_data"}, bus.load_data, v.exp);
    @(posedge clk); #1;
    mem_en = 1'b0;
    @(negedge clk);
    chk({tag, ".resp_pulse"}, 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int stall_cnt;
    int pulses;
    bit seen;
    vec_t v;

    checks   = 0;
    failures = 0;
    vecs[0] = '{1'b0, F3_LB,  32'h0800_0003, 32'h0,           32'h0000_0080, 1, SZ_BYTE, 32'hFFFF_FF80};
    vecs[1] = '{1'b0, F3_LBU, 32'h0800_0003, 32'h0,           32'h0000_0080, 1, SZ_BYTE, 32'h0000_0080};
    vecs[2] = '{1'b1, F3_SH,  32'h0800_0002, 32'h1234_ABCD,   32'h0,         1, SZ_HALF, 32'h0000_ABCD};
    vecs[3] = '{1'b0, F3_LH,  32'h0800_0002, 32'h0,           32'h1234_8001, 2, SZ_HALF, 32'hFFFF_8001};
    vecs[4] = '{1'b0, F3_LHU, 32'h0800_0000, 32'h0,           32'hABCD_7FFE, 1, SZ_HALF, 32'h0000_7FFE};
    vecs[5] = '{1'b0, F3_LW,  32'h0800_0004, 32'h0,           32'hDEAD_BEEF, 3, SZ_WORD, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, F3_SB,  32'h0800_0001, 32'hCAFE_F00D,   32'h0,         1, SZ_BYTE, 32'h0000_000D};
    vecs[7] = '{1'b1, F3_SW,  32'h0800_0008, 32'h89AB_CDEF,   32'h0,         2, SZ_WORD, 32'h89AB_CDEF};
    vecs[8] = '{1'b0, F3_LB,  32'h0800_0001, 32'h0,           32'h1234_567F, 1, SZ_BYTE, 32'h0000_007F};

    rst            = 1'b1;
    mem_en         = 1'b0;
    mem_drv        = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.flush      = 1'b0;
    bus.ACKD_n     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    mem_en  = 1'b1;
    mem_drv = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("rst.MREQ",       32'(bus.MREQ), 32'd0);
    chk("rst.WRITE",      32'(bus.WRITE), 32'd0);
    chk("rst.SIZE",       32'(bus.SIZE), 32'd0);
    chk("rst.DAD",        bus.DAD, 32'h0);
    chk("rst.stall",      32'(bus.stall), 32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.bus_err",    32'(bus.bus_err), 32'd0);
    chk("rst.load_data",  bus.load_data, 32'h0);
    chk("rst.exc_tval",   bus.exc_tval, 32'h0);
    chk("rst.DDT_z",      ddt, 32'h5A5A_5A5A);
    @(posedge clk); #1;
    rst    = 1'b0;
    mem_en = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Misaligned requests are refused without stalling
    drive_req(1'b0, F3_LW, 32'h0800_0002, 32'h0);
    @(negedge clk);
    chk("mis.lw.misalign", 32'(bus.misalign), 32'd1);
    chk("mis.lw.exc_tval", bus.exc_tval, 32'h0800_0002);
    chk("mis.lw.stall",    32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis.lw.MREQ",     32'(bus.MREQ), 32'd0);
    chk("mis.lw.stall2",   32'(bus.stall), 32'd0);
    bus.req_funct3 = F3_LH;
    bus.req_addr   = 32'h0800_0001;
    #1;
    chk("mis.lh.misalign", 32'(bus.misalign), 32'd1);
    chk("mis.lh.exc_tval", bus.exc_tval, 32'h0800_0001);
    bus.req_valid = 1'b0;
    #1;
    chk("mis.novalid",     32'(bus.misalign), 32'd0);
    @(posedge clk); #1;

    // flush in IDLE blocks acceptance
    drive_req(1'b0, F3_LW, 32'h0800_0000, 32'h0);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush.stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush.MREQ",  32'(bus.MREQ), 32'd0);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;

    // Timeout: ACKD_n never asserted
    drive_req(1'b0, F3_LW, 32'h0800_0010, 32'h0);
    bus.ACKD_n = 1'b1;
    mem_en     = 1'b0;
    stall_cnt  = 0;
    seen       = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.stall) stall_cnt++;
      @(posedge clk); #1;
    end
    chk("tmo.seen",       32'(seen), 32'd1);
    chk("tmo.stall_cnt",  32'(stall_cnt), 32'd257);
    chk("tmo.bus_err",    32'(bus.bus_err), 32'd1);
    chk("tmo.exc_tval",   bus.exc_tval, 32'h0800_0010);
    chk("tmo.MREQ",       32'(bus.MREQ), 32'd0);
    bus.req_valid = 1'b0;
    #1;
    chk("tmo.stall_resp", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo.err_pulse",  32'(bus.bus_err), 32'd0);
    @(posedge clk); #1;

    // Back-to-back LW then SW, memory latency 3
    drive_req(1'b0, F3_LW, 32'h0800_0000, 32'h0);
    @(negedge clk);
    chk("b2b.stall_acc1", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      bus.ACKD_n = (k == 3) ? 1'b0 : 1'b1;
      mem_en     = 1'b1;
      mem_drv    = 32'h1122_3344;
      @(negedge clk);
      if (bus.MREQ) n++;
      @(posedge clk); #1;
    end
    drive_req(1'b1, F3_SW, 32'h0800_0004, 32'h5566_7788);
    bus.ACKD_n = 1'b1;
    mem_en     = 1'b0;
    @(negedge clk);
    chk("b2b.mreq1",      32'(n), 32'd3);
    chk("b2b.resp1",      32'(bus.resp_valid), 32'd1);
    chk("b2b.load1",      bus.load_data, 32'h1122_3344);
    chk("b2b.gap_MREQ",   32'(bus.MREQ), 32'd0);
    chk("b2b.stall_acc2", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      bus.ACKD_n = (k == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.MREQ) n++;
      if (k == 1) begin
        chk("b2b.DAD2",   bus.DAD, 32'h0800_0004);
        chk("b2b.WRITE2", 32'(bus.WRITE), 32'd1);
        chk("b2b.DDT2",   ddt, 32'h5566_7788);
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.ACKD_n    = 1'b1;
    @(negedge clk);
    chk("b2b.mreq2",       32'(n), 32'd3);
    chk("b2b.resp2",       32'(bus.resp_valid), 32'd1);
    chk("b2b.stall_resp2", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;

    // Reset during the second ACCESS cycle
    drive_req(1'b0, F3_LW, 32'h0800_0020, 32'h0);
    bus.ACKD_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsta.MREQ_pre", 32'(bus.MREQ), 32'd1);
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rsta.MREQ",  32'(bus.MREQ), 32'd0);
    chk("rsta.stall", 32'(bus.stall), 32'd0);
    chk("rsta.resp",  32'(bus.resp_valid), 32'd0);
    bus.ACKD_n = 1'b0;
    pulses     = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.resp_valid) pulses++;
    end
    chk("rsta.no_resp", 32'(pulses), 32'd0);
    bus.ACKD_n = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, F3_LW, 32'h0800_0024, 32'h0, 32'h0BAD_F00D, 2, SZ_WORD, 32'h0BAD_F00D};
    do_txn(v, "rsta.fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
